// File: rtl/iron_violet_pkg.sv
// Shared types for the note sequencer: note codes, FSM states and melody step layout.
// Step byte: [7]=rest, [6:5]=note, [4:0]=duration in ticks.
package iron_violet_pkg;

  typedef enum logic [1:0] {
    NOTE_FS5 = 2'd0,
    NOTE_A5  = 2'd1,
    NOTE_CS6 = 2'd2,
    NOTE_E6  = 2'd3
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_REST = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int STEP_W        = 8;
  localparam int STEP_REST_BIT = 7;
  localparam int STEP_NOTE_LSB = 5;
  localparam int STEP_DUR_W    = 5;

  typedef struct packed {
    logic                  rest;
    note_e                 note;
    logic [STEP_DUR_W-1:0] dur;
  } step_t;

  function automatic step_t unpack_step(input logic [STEP_W-1:0] b);
    step_t s;
    s.rest = b[STEP_REST_BIT];
    s.note = note_e'(b[STEP_NOTE_LSB +: 2]);
    s.dur  = b[STEP_DUR_W-1:0];
    return s;
  endfunction

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Duration prescaler: tick is high in the last cycle of every TICK_DIV-cycle period.
// Latency: first tick TICK_DIV cycles after clr drops; no backpressure, clr restarts the period.
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Walks a packed melody table and drives oscillator enable/note select with tick-based durations.
// Latency: outputs reflect step 0 one cycle after start; no backpressure, stop aborts next cycle.
module note_sequencer
  import iron_violet_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int NUM_STEPS = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  input  logic [NUM_STEPS*STEP_W-1:0] seq_data,
  output logic                        en,
  output logic [1:0]                  note_sel,
  output logic [3:0]                  step_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam logic [STEP_DUR_W-1:0] GAP_DUR  = STEP_DUR_W'(GAP_TICKS);
  localparam logic [3:0]            LAST_IDX = 4'(NUM_STEPS - 1);

  seq_state_e            state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [STEP_DUR_W-1:0] dur_q, dur_d;
  logic [STEP_DUR_W-1:0] tcnt_q, tcnt_d;
  logic                  en_q, en_d;
  note_e                 note_q, note_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tick, tick_clr;
  step_t                 steps [NUM_STEPS];
  step_t                 nxt_step, ld_step;
  logic [3:0]            nxt_idx, ld_idx;
  logic [STEP_DUR_W-1:0] target;
  logic                  phase_done, load_next, load_first, do_load, finish;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    for (int k = 0; k < NUM_STEPS; k++) begin
      steps[k] = unpack_step(seq_data[k*STEP_W +: STEP_W]);
    end
  end

  always_comb begin
    nxt_idx  = idx_q + 4'd1;
    nxt_step = steps[0];
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (4'(k) == nxt_idx) nxt_step = steps[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dur_d      = dur_q;
    tcnt_d     = tcnt_q;
    en_d       = en_q;
    note_d     = note_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tick_clr   = (state_q == ST_IDLE);
    load_next  = 1'b0;
    load_first = 1'b0;
    do_load    = 1'b0;
    finish     = 1'b0;
    ld_step    = steps[0];
    ld_idx     = 4'd0;

    target     = (state_q == ST_GAP) ? GAP_DUR : dur_q;
    phase_done = tick && (tcnt_q == target - 5'd1);
    if (tick && !phase_done) tcnt_d = tcnt_q + 5'd1;

    case (state_q)
      ST_IDLE: if (start) load_first = 1'b1;
      ST_NOTE: begin
        if (phase_done) begin
          if (GAP_TICKS > 0) begin
            state_d  = ST_GAP;
            en_d     = 1'b0;
            tcnt_d   = '0;
            tick_clr = 1'b1;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      ST_REST, ST_GAP: if (phase_done) load_next = 1'b1;
      default: ;
    endcase

    // A zero-duration step or running off the table both end the sequence.
    if (load_next) begin
      if ((idx_q == LAST_IDX) || (nxt_step.dur == '0)) begin
        if (loop) load_first = 1'b1;
        else      finish     = 1'b1;
      end else begin
        do_load = 1'b1;
        ld_step = nxt_step;
        ld_idx  = nxt_idx;
      end
    end

    if (load_first) begin
      if (steps[0].dur == '0) begin
        finish = 1'b1;
      end else begin
        do_load = 1'b1;
        ld_step = steps[0];
        ld_idx  = 4'd0;
      end
    end

    if (do_load) begin
      state_d  = ld_step.rest ? ST_REST : ST_NOTE;
      idx_d    = ld_idx;
      dur_d    = ld_step.dur;
      en_d     = !ld_step.rest;
      busy_d   = 1'b1;
      tcnt_d   = '0;
      tick_clr = 1'b1;
      if (!ld_step.rest) note_d = ld_step.note;
    end

    if (finish) begin
      state_d  = ST_IDLE;
      idx_d    = 4'd0;
      en_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      tcnt_d   = '0;
      tick_clr = 1'b1;
    end

    // Stop overrides everything, including a same-cycle start or sequence end.
    if (stop) begin
      state_d  = ST_IDLE;
      idx_d    = 4'd0;
      en_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      tcnt_d   = '0;
      tick_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      dur_q   <= '0;
      tcnt_q  <= '0;
      en_q    <= 1'b0;
      note_q  <= NOTE_FS5;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      tcnt_q  <= tcnt_d;
      en_q    <= en_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign en       = en_q;
  assign note_sel = note_q;
  assign step_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: TICK_DIV=10, 4 steps, 1 gap tick.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop;
  logic [31:0] seq_data;
  logic        en;
  logic [1:0]  note_sel;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // {F#5 d2, E6 d1, rest d2, A5 d3}
  localparam logic [31:0] TBL1      = 32'h0261_8223;
  localparam logic [31:0] TBL_S2Z   = 32'h0260_8223;
  localparam logic [31:0] TBL_S0Z   = 32'h0261_8220;

  note_sequencer #(
    .CLK_FREQ  (1000),
    .TICK_HZ   (100),
    .NUM_STEPS (4),
    .GAP_TICKS (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .seq_data (seq_data),
    .en       (en),
    .note_sel (note_sel),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks n consecutive cycles against one expected output pattern; done must stay low.
  task automatic seg(input string tag, input logic e, input logic [1:0] ns, input logic cn,
                     input logic [3:0] idx, input logic b, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (en !== e || busy !== b || done !== 1'b0 || step_idx !== idx ||
          (cn && note_sel !== ns)) bad++;
      @(negedge clk);
    end
    chk(tag, bad, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic play_rest(input string p);
    seg({p, "_gap0"},  1'b0, 2'd1, 1'b1, 4'd0, 1'b1, 10);
    seg({p, "_rest1"}, 1'b0, 2'd0, 1'b0, 4'd1, 1'b1, 20);
    seg({p, "_note2"}, 1'b1, 2'd3, 1'b1, 4'd2, 1'b1, 10);
    seg({p, "_gap2"},  1'b0, 2'd3, 1'b1, 4'd2, 1'b1, 10);
    seg({p, "_note3"}, 1'b1, 2'd0, 1'b1, 4'd3, 1'b1, 20);
    seg({p, "_gap3"},  1'b0, 2'd0, 1'b1, 4'd3, 1'b1, 10);
  endtask

  task automatic play_pass(input string p);
    seg({p, "_note0"}, 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 30);
    play_rest(p);
  endtask

  // Expects {done,busy,en,step_idx} = {1,0,0,0} now and done low one cycle later.
  task automatic end_check(input string tag);
    chk({tag, "_done"}, {25'd0, done, busy, en, step_idx}, 32'h40);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'h0);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop     = 1'b0;
    seq_data = TBL1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {23'd0, en, note_sel, step_idx, busy, done}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", {23'd0, en, note_sel, step_idx, busy, done}, 32'h0);

    // 1: single non-looping pass
    pulse_start();
    play_pass("t1");
    end_check("t1_end");

    // 2: zero duration at step 2 ends the sequence after step 1
    seq_data = TBL_S2Z;
    pulse_start();
    seg("t2_note0", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 30);
    seg("t2_gap0",  1'b0, 2'd1, 1'b1, 4'd0, 1'b1, 10);
    seg("t2_rest1", 1'b0, 2'd0, 1'b0, 4'd1, 1'b1, 20);
    end_check("t2_end");
    seg("t2_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 30);

    // 3: loop restarts without an idle cycle; dropping loop ends after the pass
    seq_data = TBL1;
    loop     = 1'b1;
    pulse_start();
    play_pass("t3a");
    loop = 1'b0;
    play_pass("t3b");
    end_check("t3_end");

    // 4: stop mid-step, and start together with stop
    pulse_start();
    seg("t4_pre", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 14);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_stop", {28'd0, en, busy, done, |step_idx}, 32'h0);
    seg("t4_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 20);
    pulse_start();
    seg("t4b_note0", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 30);
    seg("t4b_gap0",  1'b0, 2'd1, 1'b1, 4'd0, 1'b1, 10);
    seg("t4b_rest1", 1'b0, 2'd0, 1'b0, 4'd1, 1'b1, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_stop_rest", {24'd0, en, busy, done, 1'b0, step_idx}, 32'h0);
    seg("t4b_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 20);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    seg("t4_start_stop", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 20);

    // 5: zero-duration step 0 gives an immediate done; start while busy is ignored
    seq_data = TBL_S0Z;
    loop     = 1'b1;
    pulse_start();
    end_check("t5_s0z");
    seg("t5_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 20);
    loop     = 1'b0;
    seq_data = TBL1;
    pulse_start();
    seg("t5_note0a", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 12);
    start = 1'b1;
    seg("t5_note0b", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 1);
    start = 1'b0;
    seg("t5_note0c", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 17);
    play_rest("t5");
    end_check("t5_end");

    // 6: asynchronous reset in the middle of a note
    pulse_start();
    seg("t6_pre", 1'b1, 2'd1, 1'b1, 4'd0, 1'b1, 5);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", {23'd0, en, note_sel, step_idx, busy, done}, 32'h0);
    @(negedge clk);
    chk("t6_held", {23'd0, en, note_sel, step_idx, busy, done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    play_pass("t6");
    end_check("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
